// File: rtl/adia_pkg.sv
// Shared definitions for the adiabatic mux driver.
//   phase_e  : FSM state encoding, also exported on the debug phase port.
//   step_max : full-swing DAC code (2^w - 1) for a given code width.
package adia_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RAMP_UP = 3'd2,
    HOLD    = 3'd3,
    RAMP_DN = 3'd4
  } phase_e;

  function automatic int unsigned step_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/adia_mux_driver_if.sv
// Request/mux/power-clock bundle of the adiabatic mux driver.
//   master : upstream side (drives req_*, observes everything else).
//   slave  : the driver (accepts req_*, drives mux pins, DAC codes, status).
interface adia_mux_driver_if #(
  parameter int DATA_W = 1,
  parameter int STEP_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_sel;
  logic [DATA_W-1:0] mux_a;
  logic [DATA_W-1:0] mux_b;
  logic              mux_in;
  logic [STEP_W-1:0] clkpos_code;
  logic [STEP_W-1:0] clkneg_code;
  logic [2:0]        phase;
  logic              hold_valid;
  logic              done;

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready, mux_a, mux_b, mux_in, clkpos_code, clkneg_code,
           phase, hold_valid, done
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready, mux_a, mux_b, mux_in, clkpos_code, clkneg_code,
           phase, hold_valid, done
  );
endinterface

// File: rtl/adia_ramp_counter.sv
// Saturating up/down step counter for the power-clock DAC code.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   inc, dec   : step up / down one LSB (dec wins); ignored at the rail
//   clear      : force to 0 (highest priority)
//   cnt        : current code; at_max / at_zero : rail flags
module adia_ramp_counter
  import adia_pkg::*;
#(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              clear,
  output logic [STEP_W-1:0] cnt,
  output logic              at_max,
  output logic              at_zero
);
  localparam logic [STEP_W-1:0] MAX = STEP_W'(step_max(STEP_W));

  assign at_max  = (cnt == MAX);
  assign at_zero = (cnt == '0);

  // Rail checks keep the count from ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (dec && !at_zero)  cnt <= cnt - STEP_W'(1);
    else if (inc && !at_max)   cnt <= cnt + STEP_W'(1);
  end
endmodule

// File: rtl/adia_mux_driver.sv
// Upstream driver for the adiabatic 2:1 mux cell array.
// Accepts an operand pair + select over valid/ready, holds them on the mux
// pins and sequences the complementary power-clock DAC codes:
// IDLE -> SETUP -> RAMP_UP -> HOLD -> RAMP_DN -> IDLE.
// Mux inputs only change in IDLE, i.e. while the power clock is at rest.
//   clk, rst_n : clock, async active-low reset
//   bus        : adia_mux_driver_if.slave (request, mux pins, codes, status)
//   abort      : only with ADIA_ABORT_EN defined; early ramp-down from
//                RAMP_UP or HOLD
module adia_mux_driver
  import adia_pkg::*;
#(
  parameter int DATA_W      = 1,
  parameter int STEP_W      = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ADIA_ABORT_EN
  input  logic abort,
`endif
  adia_mux_driver_if.slave bus
);
  localparam logic [STEP_W-1:0] MAX  = STEP_W'(step_max(STEP_W));
  localparam int                HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  phase_e            state;
  logic [HC_W-1:0]   hold_cnt;
  logic [DATA_W-1:0] a_q, b_q;
  logic              sel_q, hold_valid_q, done_q;
  logic [STEP_W-1:0] cnt;
  logic              at_max, at_zero;
  logic              cnt_inc, cnt_dec, cnt_clear;
  logic              hold_last, abort_hit;

  assign hold_last = (hold_cnt == HC_W'(HOLD_CYCLES - 1));

`ifdef ADIA_ABORT_EN
  assign abort_hit = abort && (state == RAMP_UP || state == HOLD);
`else
  assign abort_hit = 1'b0;
`endif

  // Counter steering: every code move is a single LSB, so the ramp is
  // always gradual outside reset.
  always_comb begin
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = (state == IDLE);
    case (state)
      SETUP:   cnt_inc = 1'b1;
      RAMP_UP: if (abort_hit) cnt_dec = 1'b1;
               else if (!at_max) cnt_inc = 1'b1;
      HOLD:    cnt_dec = abort_hit || hold_last;
      RAMP_DN: cnt_dec = !at_zero;
      default: ;
    endcase
  end

  adia_ramp_counter #(.STEP_W(STEP_W)) u_ramp (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .dec     (cnt_dec),
    .clear   (cnt_clear),
    .cnt     (cnt),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      hold_valid_q <= 1'b0;
      done_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= 1'b0;
    end else begin
      // Any decrement from code 1 lands on 0: that is the final ramp-down
      // cycle, whether reached normally or through an abort.
      done_q <= cnt_dec && (cnt == STEP_W'(1));
      case (state)
        IDLE: if (bus.req_valid) begin
          state <= SETUP;
          a_q   <= bus.req_a;
          b_q   <= bus.req_b;
          sel_q <= bus.req_sel;
        end
        SETUP: state <= RAMP_UP;
        RAMP_UP: begin
          if (abort_hit) state <= RAMP_DN;
          else if (at_max) begin
            state        <= HOLD;
            hold_valid_q <= 1'b1;
            hold_cnt     <= '0;
          end
        end
        HOLD: begin
          if (abort_hit || hold_last) begin
            state        <= RAMP_DN;
            hold_valid_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        RAMP_DN: if (at_zero) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.mux_a       = a_q;
  assign bus.mux_b       = b_q;
  assign bus.mux_in      = sel_q;
  assign bus.clkpos_code = cnt;
  assign bus.clkneg_code = MAX - cnt;
  assign bus.phase       = state;
  assign bus.hold_valid  = hold_valid_q;
  assign bus.done        = done_q;
endmodule
